// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one byte-oriented SPI master among NUM_REQ clients,
// with a watchdog that turns a missing spi_done into an err pulse to the winner.
module spi_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] cmd_in,
    input  logic [8*NUM_REQ-1:0] addr_in,
    input  logic [8*NUM_REQ-1:0] wdata_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   err,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic                 spi_en,
    output logic [7:0]           spi_command,
    output logic [7:0]           spi_address,
    output logic [7:0]           spi_data,
    input  logic [7:0]           spi_data_out,
    input  logic                 spi_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               spi_en_q, spi_en_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         wdat_q, wdat_d;

    logic [7:0]         cmd_arr  [NUM_REQ];
    logic [7:0]         addr_arr [NUM_REQ];
    logic [7:0]         wdat_arr [NUM_REQ];
    logic [IW-1:0]      pick;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign cmd_arr[gi]  = cmd_in[8*gi +: 8];
        assign addr_arr[gi] = addr_in[8*gi +: 8];
        assign wdat_arr[gi] = wdata_in[8*gi +: 8];
    end

    // Scan from the highest offset down so the request closest to ptr wins last.
    always_comb begin
        int idx;
        pick = ptr_q;
        idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) pick = IW'(idx);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        spi_en_d = 1'b0;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        case (state_q)
            S_IDLE: begin
                if (req != '0) begin
                    win_d    = pick;
                    gnt_d    = ONE << pick;
                    cmd_d    = cmd_arr[pick];
                    addr_d   = addr_arr[pick];
                    wdat_d   = wdat_arr[pick];
                    spi_en_d = 1'b1;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A done arriving on the terminal count still counts as success.
                if (spi_done) begin
                    rdata_d = spi_data_out;
                    ack_d   = ONE << win_q;
                    state_d = S_RESP;
                end else if (cnt_q == LAST_CNT) begin
                    err_d   = ONE << win_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                gnt_d   = '0;
                ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            spi_en_q <= 1'b0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            spi_en_q <= spi_en_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign spi_en      = spi_en_q;
    assign spi_command = cmd_q;
    assign spi_address = addr_q;
    assign spi_data    = wdat_q;
endmodule
